// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Holds the access-size encodings, the bus FSM state enum, the base write
// strobes and the alignment rule used to reject misaligned accesses.
package mem_pkg;

  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10,
    SizeRsvd = 2'b11  // reserved, behaves as a word access
  } mem_size_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StDone = 2'b10
  } mem_state_e;

  // Base strobes for lane 0; shifted left by the byte offset at capture time.
  localparam logic [3:0] StrbByte = 4'b0001;
  localparam logic [3:0] StrbHalf = 4'b0011;
  localparam logic [3:0] StrbWord = 4'b1111;

  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
    logic mis;
    case (size)
      SizeByte: mis = 1'b0;
      SizeHalf: mis = off[0];
      default:  mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: selects the byte/half lane addressed by offset_i out of
// a 32-bit bus word and sign- or zero-extends it to 32 bits.
//   rdata_i    raw word returned by the bus
//   offset_i   byte offset of the access inside the word
//   size_i     access size
//   unsigned_i 1 = zero-extend, 0 = sign-extend
//   data_o     right-aligned, extended load value
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  mem_size_e   size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  // Move the addressed lane down to bit 0; word accesses always have offset 0.
  assign shifted = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (size_i)
      SizeByte: data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      SizeHalf: data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      default:  data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage memory access unit. Accepts one load/store from the pipeline,
// runs a single request/acknowledge bus transaction, stalls the front of the
// pipeline while it is outstanding and returns the extended load data to WB.
//   clk, resetn            clock, asynchronous active-low reset
//   M_*                    MEM-stage request, stall and misalignment flag
//   W_mem_data/valid/err   write-back result, one-cycle valid pulse
//   bus_*                  word-aligned request/ack memory bus
// A request that sees no ack within TIMEOUT cycles completes with W_bus_err.
module mem_access
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        M_valid,
  input  logic        M_mem_read,
  input  logic        M_mem_write,
  input  logic [1:0]  M_mem_size,
  input  logic        M_mem_unsigned,
  input  logic [31:0] M_addr,
  input  logic [31:0] M_wdata,
  output logic        M_stall,
  output logic        M_addr_err,
  output logic [31:0] W_mem_data,
  output logic        W_mem_valid,
  output logic        W_bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  mem_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]    addr_q;
  mem_size_e      size_q;
  logic           uns_q;
  logic           we_q;
  logic [3:0]     strb_q;
  logic [31:0]    wdata_q;
  logic [31:0]    mdata_q;
  logic           berr_q;

  mem_size_e   size_in;
  logic        access;
  logic        accept;
  logic [3:0]  strb_in;
  logic [31:0] wdata_in;
  logic        capture;
  logic        done_ack;
  logic        done_to;
  logic [31:0] load_data;

  assign size_in    = mem_size_e'(M_mem_size);
  assign access     = M_valid & (M_mem_read | M_mem_write);
  assign M_addr_err = access & is_misaligned(size_in, M_addr[1:0]);
  assign accept     = access & ~M_addr_err;

  // Store lane strobes and replicated write data; loads drive neither.
  always_comb begin
    strb_in  = 4'b0000;
    wdata_in = 32'h0;
    if (M_mem_write) begin
      case (size_in)
        SizeByte: begin
          strb_in  = StrbByte << M_addr[1:0];
          wdata_in = {4{M_wdata[7:0]}};
        end
        SizeHalf: begin
          strb_in  = StrbHalf << M_addr[1:0];
          wdata_in = {2{M_wdata[15:0]}};
        end
        default: begin
          strb_in  = StrbWord;
          wdata_in = M_wdata;
        end
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    done_ack = 1'b0;
    done_to  = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StReq;
          cnt_d   = '0;
          capture = 1'b1;
        end
      end
      StReq: begin
        // An ack on the last allowed cycle still completes normally.
        if (bus_ack) begin
          state_d  = StDone;
          done_ack = 1'b1;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d = StDone;
          done_to = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= 32'h0;
      size_q  <= SizeByte;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      strb_q  <= 4'b0000;
      wdata_q <= 32'h0;
      mdata_q <= 32'h0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q  <= M_addr;
        size_q  <= size_in;
        uns_q   <= M_mem_unsigned;
        we_q    <= M_mem_write;
        strb_q  <= strb_in;
        wdata_q <= wdata_in;
      end
      if (done_ack) begin
        mdata_q <= we_q ? 32'h0 : load_data;
        berr_q  <= 1'b0;
      end else if (done_to) begin
        mdata_q <= 32'h0;
        berr_q  <= 1'b1;
      end
    end
  end

  load_align u_load_align (
    .rdata_i    (bus_rdata),
    .offset_i   (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_data)
  );

  assign bus_req     = (state_q == StReq);
  assign bus_we      = we_q;
  assign bus_addr    = {addr_q[31:2], 2'b00};
  assign bus_wstrb   = strb_q;
  assign bus_wdata   = wdata_q;
  assign W_mem_data  = mdata_q;
  assign W_mem_valid = (state_q == StDone);
  assign W_bus_err   = (state_q == StDone) & berr_q;
  // Gated by resetn so the combinational accept term cannot stall during reset.
  assign M_stall     = resetn & (((state_q == StIdle) & accept) | (state_q == StReq));

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  localparam int Timeout = 16;
  localparam int NoAck   = 255;

  logic        clk = 1'b0;
  logic        resetn;
  logic        M_valid, M_mem_read, M_mem_write, M_mem_unsigned;
  logic [1:0]  M_mem_size;
  logic [31:0] M_addr, M_wdata;
  logic        M_stall, M_addr_err;
  logic [31:0] W_mem_data;
  logic        W_mem_valid, W_bus_err;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(Timeout)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .M_valid        (M_valid),
    .M_mem_read     (M_mem_read),
    .M_mem_write    (M_mem_write),
    .M_mem_size     (M_mem_size),
    .M_mem_unsigned (M_mem_unsigned),
    .M_addr         (M_addr),
    .M_wdata        (M_wdata),
    .M_stall        (M_stall),
    .M_addr_err     (M_addr_err),
    .W_mem_data     (W_mem_data),
    .W_mem_valid    (W_mem_valid),
    .W_bus_err      (W_bus_err),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wstrb      (bus_wstrb),
    .bus_wdata      (bus_wdata),
    .bus_ack        (bus_ack),
    .bus_rdata      (bus_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;        // REQ cycles before ack; >= Timeout means never
    logic        exp_err;
    logic        exp_we;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdat;
    logic [31:0] exp_baddr;
    logic [31:0] exp_mdata;
    logic        exp_berr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic rd, logic wr, logic [1:0] size, logic uns,
                              logic [31:0] addr, logic [31:0] wdata, logic [31:0] rdata,
                              int dly, logic err, logic we, logic [3:0] strb,
                              logic [31:0] wdat, logic [31:0] baddr, logic [31:0] mdata,
                              logic berr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.size = size; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.dly = dly; v.exp_err = err; v.exp_we = we;
    v.exp_strb = strb; v.exp_wdat = wdat; v.exp_baddr = baddr; v.exp_mdata = mdata;
    v.exp_berr = berr;
    return v;
  endfunction

  // Reference model: derives every expectation from access width and byte offset.
  function automatic vec_t model(vec_t v);
    int          n, off;
    logic [31:0] mask, val;
    n   = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    off = int'(v.addr[1:0]);
    v.exp_err   = (v.addr % n) != 0;
    v.exp_we    = v.wr;
    v.exp_baddr = v.addr - off;
    v.exp_strb  = v.wr ? 4'(((1 << n) - 1) << off) : 4'b0;
    v.exp_wdat  = 32'h0;
    if (v.wr)
      for (int i = 0; i < 4; i++) v.exp_wdat[8*i +: 8] = v.wdata[8*(i % n) +: 8];
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 1);
    val  = (v.rdata >> (8 * off)) & mask;
    if (!v.uns && val[8*n-1]) val = val | ~mask;
    v.exp_berr  = v.dly >= Timeout;
    v.exp_mdata = v.exp_berr ? 32'h0 : val;
    return v;
  endfunction

  // Starts on a falling edge with the DUT idle; returns on a falling edge, idle again.
  task automatic run_txn(input vec_t v);
    int exp_req, req_n, req_hi, stall_n;
    M_valid = 1'b1; M_mem_read = v.rd; M_mem_write = v.wr; M_mem_size = v.size;
    M_mem_unsigned = v.uns; M_addr = v.addr; M_wdata = v.wdata; bus_rdata = v.rdata;
    bus_ack = 1'($urandom_range(0, 1));  // must be ignored while idle
    #1;
    check("addr_err", M_addr_err, v.exp_err);
    check("stall_accept", M_stall, !v.exp_err);
    check("req_idle", bus_req, 0);
    if (v.exp_err) begin
      @(negedge clk);
      check("misaligned_no_req", bus_req, 0);
      check("misaligned_no_stall", M_stall, 0);
      check("misaligned_no_valid", W_mem_valid, 0);
      M_valid = 1'b0; bus_ack = 1'b0;
      return;
    end
    exp_req = (v.dly >= Timeout) ? Timeout : v.dly + 1;
    @(negedge clk);
    req_n = 0; req_hi = 0; stall_n = 1;
    while (!W_mem_valid && req_n < Timeout + 4) begin
      if (req_n == 0) begin
        check("bus_addr", bus_addr, v.exp_baddr);
        check("bus_we", bus_we, v.exp_we);
        check("bus_wstrb", bus_wstrb, v.exp_strb);
        if (v.exp_we) check("bus_wdata", bus_wdata, v.exp_wdat);
      end
      if (bus_req) req_hi++;
      if (M_stall) stall_n++;
      bus_ack = (req_n == v.dly);
      req_n++;
      @(negedge clk);
    end
    bus_ack = 1'($urandom_range(0, 1));  // ignored in DONE
    check("done_reached", W_mem_valid, 1);
    check("req_cycles", req_n, exp_req);
    check("req_high_cycles", req_hi, exp_req);
    check("stall_cycles", stall_n, exp_req + 1);
    check("done_stall", M_stall, 0);
    check("done_req", bus_req, 0);
    check("bus_err", W_bus_err, v.exp_berr);
    if (!v.exp_we || v.exp_berr) check("mem_data", W_mem_data, v.exp_mdata);
    M_valid = 1'b0;
    @(negedge clk);
    bus_ack = 1'b0;
    check("valid_pulse", W_mem_valid, 0);
    check("err_pulse", W_bus_err, 0);
    if (!v.exp_we || v.exp_berr) check("mem_data_held", W_mem_data, v.exp_mdata);
  endtask

  vec_t vecs[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   k;
    resetn = 1'b0; M_valid = 1'b0; M_mem_read = 1'b0; M_mem_write = 1'b0;
    M_mem_size = 2'd0; M_mem_unsigned = 1'b0; M_addr = 32'h0; M_wdata = 32'h0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    #1;
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_bus_wstrb", bus_wstrb, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_mem_data", W_mem_data, 0);
    check("rst_mem_valid", W_mem_valid, 0);
    check("rst_bus_err", W_bus_err, 0);
    check("rst_stall", M_stall, 0);
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    //           rd wr sz us addr          wdata         rdata         dly    err we strb     wdat          baddr         mdata         berr
    vecs[0]  = mk(1, 0, 0, 0, 32'h0000_1003, 32'h0,        32'h80FF_FFFF, 1,     0, 0, 4'b0000, 32'h0,        32'h0000_1000, 32'hFFFF_FF80, 0);
    vecs[1]  = mk(0, 1, 1, 0, 32'h0000_2002, 32'h0000_ABCD, 32'h0,       0,     0, 1, 4'b1100, 32'hABCD_ABCD, 32'h0000_2000, 32'h0,        0);
    vecs[2]  = mk(1, 0, 2, 0, 32'h0000_3001, 32'h0,        32'h0,        0,     1, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        0);
    vecs[3]  = mk(1, 0, 2, 0, 32'h0000_4000, 32'h0,        32'hCAFE_F00D, NoAck, 0, 0, 4'b0000, 32'h0,        32'h0000_4000, 32'h0,        1);
    vecs[4]  = mk(1, 0, 0, 1, 32'h0000_5001, 32'h0,        32'h1234_8056, 0,     0, 0, 4'b0000, 32'h0,        32'h0000_5000, 32'h0000_0080, 0);
    vecs[5]  = mk(1, 0, 1, 0, 32'h0000_6002, 32'h0,        32'h9ABC_1234, 2,     0, 0, 4'b0000, 32'h0,        32'h0000_6000, 32'hFFFF_9ABC, 0);
    vecs[6]  = mk(0, 1, 0, 0, 32'h0000_7001, 32'hFFFF_FF5A, 32'h0,       3,     0, 1, 4'b0010, 32'h5A5A_5A5A, 32'h0000_7000, 32'h0,        0);
    vecs[7]  = mk(0, 1, 2, 0, 32'h0000_8000, 32'hDEAD_BEEF, 32'h0,       15,    0, 1, 4'b1111, 32'hDEAD_BEEF, 32'h0000_8000, 32'h0,        0);
    vecs[8]  = mk(0, 1, 1, 0, 32'h0000_9001, 32'h1111_2222, 32'h0,       0,     1, 1, 4'b0000, 32'h0,        32'h0,        32'h0,        0);
    vecs[9]  = mk(1, 0, 3, 0, 32'h0000_A000, 32'h0,        32'h8765_4321, 0,     0, 0, 4'b0000, 32'h0,        32'h0000_A000, 32'h8765_4321, 0);
    vecs[10] = mk(1, 1, 2, 0, 32'h0000_B004, 32'h1122_3344, 32'h0,       1,     0, 1, 4'b1111, 32'h1122_3344, 32'h0000_B004, 32'h0,        0);
    vecs[11] = mk(1, 0, 1, 1, 32'h0000_C000, 32'h0,        32'hFFFF_8001, 0,     0, 0, 4'b0000, 32'h0,        32'h0000_C000, 32'h0000_8001, 0);
    vecs[12] = mk(1, 0, 0, 0, 32'h0000_D002, 32'h0,        32'h007F_0000, 0,     0, 0, 4'b0000, 32'h0,        32'h0000_D000, 32'h0000_007F, 0);
    vecs[13] = mk(1, 0, 3, 0, 32'h0000_E002, 32'h0,        32'h0,        0,     1, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        0);
    vecs[14] = mk(0, 1, 0, 0, 32'h0000_F003, 32'h0000_00C3, 32'h0,       0,     0, 1, 4'b1000, 32'hC3C3_C3C3, 32'h0000_F000, 32'h0,        0);
    for (int i = 0; i < 15; i++) run_txn(vecs[i]);

    // No request when M_valid is low, or when neither read nor write is set.
    M_valid = 1'b0; M_mem_read = 1'b1; M_mem_size = 2'd2; M_addr = 32'h100;
    #1;
    check("novalid_stall", M_stall, 0);
    @(negedge clk);
    check("novalid_req", bus_req, 0);
    M_valid = 1'b1; M_mem_read = 1'b0; M_mem_write = 1'b0;
    #1;
    check("noop_stall", M_stall, 0);
    @(negedge clk);
    check("noop_req", bus_req, 0);
    M_valid = 1'b0;

    // Randomized accesses against the reference model.
    for (int i = 0; i < 150; i++) begin
      k = int'($urandom_range(0, 2));
      v.rd = (k != 1); v.wr = (k != 0);
      v.size = 2'($urandom_range(0, 3));
      v.uns  = 1'($urandom_range(0, 1));
      v.addr = $urandom; v.wdata = $urandom; v.rdata = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        if (v.size == 2'd1) v.addr[0] = 1'b0;
        else if (v.size != 2'd0) v.addr[1:0] = 2'b00;
      end
      k = int'($urandom_range(0, 9));
      v.dly = (k == 0) ? NoAck : (k == 1) ? Timeout - 1 : int'($urandom_range(0, 4));
      run_txn(model(v));
    end

    // Reset asserted in the middle of a request.
    M_valid = 1'b1; M_mem_read = 1'b1; M_mem_write = 1'b0; M_mem_size = 2'd2;
    M_mem_unsigned = 1'b0; M_addr = 32'h0000_0040; bus_rdata = 32'h5555_AAAA; bus_ack = 1'b0;
    @(negedge clk); @(negedge clk);
    check("pre_reset_req", bus_req, 1);
    #2 resetn = 1'b0;
    #1;
    check("midrst_bus_req", bus_req, 0);
    check("midrst_stall", M_stall, 0);
    check("midrst_bus_addr", bus_addr, 0);
    check("midrst_bus_wstrb", bus_wstrb, 0);
    check("midrst_mem_valid", W_mem_valid, 0);
    check("midrst_mem_data", W_mem_data, 0);
    M_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_txn(mk(1, 0, 1, 1, 32'h0, 32'h0, 32'h0000_F00F, 0,
               0, 0, 4'b0000, 32'h0, 32'h0, 32'h0000_F00F, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
